// File: rtl/alu_arb_if.sv
// Request/response bus between the requesters and alu_arbiter.
// Handshake: a transfer happens on a rising edge where valid and ready are both high; valid is held stable until then.
interface alu_arb_if #(
  parameter int N_REQ = 2,
  parameter int W     = 16
) ();
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [3*N_REQ-1:0] req_op;
  logic [W*N_REQ-1:0] req_a;
  logic [W*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]   rsp_valid;
  logic [N_REQ-1:0]   rsp_ready;
  logic [W-1:0]       rsp_result;
  logic               rsp_zero;
  logic               rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between N_REQ requesters (IDLE -> EXEC -> RESP).
// Optional macro ALU_ARB_STALL_CNT_EN adds stall_cnt, a saturating count of RESP cycles without owner ready.
module alu_arbiter #(
  parameter int N_REQ = 2,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arb_if.slave     bus,
  output logic [2:0]   alu_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_result,
  output logic         busy,
  output logic [1:0]   dbg_state
`ifdef ALU_ARB_STALL_CNT_EN
  ,
  output logic [15:0]  stall_cnt
`endif
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] owner_q;
  logic [2:0]       alu_op_q;
  logic [W-1:0]     alu_a_q;
  logic [W-1:0]     alu_b_q;
  logic [N_REQ-1:0] rsp_valid_q;
  logic [W-1:0]     rsp_result_q;
  logic             rsp_zero_q;
  logic             rsp_err_q;

  logic             grant_found;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] cand;
  logic [2:0]       sel_op;
  logic [W-1:0]     sel_a;
  logic [W-1:0]     sel_b;
  logic [N_REQ-1:0] owner_onehot;
  logic [N_REQ-1:0] req_ready_d;
  logic             owner_ready;
  logic             op_illegal;
  logic [IDX_W-1:0] owner_next;

  // Rotating priority: scan from rr_ptr upward, wrapping, and take the first valid requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % N_REQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_op = bus.req_op[3*i +: 3];
        sel_a  = bus.req_a[W*i +: W];
        sel_b  = bus.req_b[W*i +: W];
      end
    end
  end

  // req_ready is gated by rst_n so a held request is never acknowledged while reset is asserted.
  always_comb begin
    owner_onehot = '0;
    req_ready_d  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      owner_onehot[i] = (owner_q == IDX_W'(i));
      req_ready_d[i]  = rst_n && (state_q == IDLE) && grant_found && (grant_idx == IDX_W'(i));
    end
  end

  assign owner_ready = |(bus.rsp_ready & owner_onehot);
  assign op_illegal  = (alu_op_q == 3'b011) || (alu_op_q == 3'b100) || (alu_op_q == 3'b101);
  assign owner_next  = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            alu_op_q <= sel_op;
            alu_a_q  <= sel_a;
            alu_b_q  <= sel_b;
            owner_q  <= grant_idx;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          if (op_illegal) begin
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b1;
          end else begin
            rsp_result_q <= alu_result;
            rsp_zero_q   <= (alu_result == '0);
            rsp_err_q    <= 1'b0;
          end
          rsp_valid_q <= owner_onehot;
          state_q     <= RESP;
        end
        RESP: begin
          if (owner_ready) begin
            rsp_valid_q <= '0;
            rr_ptr_q    <= owner_next;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if ((state_q == RESP) && !owner_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

  assign bus.req_ready  = req_ready_d;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_err    = rsp_err_q;
  assign alu_op         = alu_op_q;
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign busy           = (state_q != IDLE);
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_alu_arbiter;
  localparam int N = 2;
  localparam int W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  alu_arb_if #(.N_REQ(N), .W(W)) bus ();

  logic [2:0]   alu_op;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_result;
  logic         busy;
  logic [1:0]   dbg_state;
`ifdef ALU_ARB_STALL_CNT_EN
  logic [15:0]  stall_cnt;
`endif

  int n_checks  = 0;
  int n_fail    = 0;
  int model_ptr = 0;
  logic [W+1:0] exp_q[$];

  alu_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .busy       (busy),
    .dbg_state  (dbg_state)
`ifdef ALU_ARB_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  // clock / reset / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // external combinational ALU; illegal ops return non-zero garbage
  function automatic logic [W-1:0] alu_ref(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: return (a ^ b) | W'(1);
    endcase
  endfunction

  function automatic bit is_illegal(input logic [2:0] op);
    return (op == 3'b011) || (op == 3'b100) || (op == 3'b101);
  endfunction

  assign alu_result = alu_ref(alu_op, alu_a, alu_b);

  // driver tasks
  task automatic drive_req(input int idx, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_valid[idx]     = 1'b1;
    bus.req_op[3*idx +: 3] = op;
    bus.req_a[W*idx +: W]  = a;
    bus.req_b[W*idx +: W]  = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0", bus.req_ready); end
    n_checks++; if (bus.rsp_valid !== '0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    n_checks++; if (bus.rsp_result !== '0) begin n_fail++; $display("FAIL reset_rsp_result: got %h expected 0", bus.rsp_result); end
    n_checks++; if ({bus.rsp_zero, bus.rsp_err} !== 2'b00) begin n_fail++; $display("FAIL reset_zero_err: got %b expected 00", {bus.rsp_zero, bus.rsp_err}); end
    n_checks++; if ({alu_op, alu_a, alu_b} !== '0) begin n_fail++; $display("FAIL reset_alu_regs: got %h/%h/%h expected 0", alu_op, alu_a, alu_b); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
`ifdef ALU_ARB_STALL_CNT_EN
    n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
`endif
    rst_n = 1'b1;
    model_ptr = 0;
  endtask

  task automatic test_add_latency();
    @(negedge clk);
    bus.rsp_ready = '1;
    drive_req(0, 3'b010, 16'h0003, 16'h0004);
    #1;
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL add_grant: got %b expected 01", bus.req_ready); end
    @(posedge clk); @(negedge clk);
    bus.req_valid[0] = 1'b0;
    #1;
    n_checks++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL add_exec_valid: got %b expected 00", bus.rsp_valid); end
    n_checks++; if ({alu_op, alu_a, alu_b} !== {3'b010, 16'h0003, 16'h0004}) begin n_fail++; $display("FAIL add_alu_regs: got %h/%h/%h expected 2/3/4", alu_op, alu_a, alu_b); end
    @(posedge clk); @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 2'b01) begin n_fail++; $display("FAIL add_rsp_valid: got %b expected 01", bus.rsp_valid); end
    n_checks++; if (bus.rsp_result !== 16'h0007) begin n_fail++; $display("FAIL add_result: got %h expected 0007", bus.rsp_result); end
    n_checks++; if ({bus.rsp_zero, bus.rsp_err} !== 2'b00) begin n_fail++; $display("FAIL add_zero_err: got %b expected 00", {bus.rsp_zero, bus.rsp_err}); end
    @(posedge clk); @(negedge clk);
    n_checks++; if ({bus.rsp_valid, busy} !== 3'b000) begin n_fail++; $display("FAIL add_done: got valid=%b busy=%b expected 00/0", bus.rsp_valid, busy); end
    model_ptr = 1;
  endtask

  task automatic test_sub_zero();
    @(negedge clk);
    bus.rsp_ready = '1;
    drive_req(1, 3'b110, 16'h1234, 16'h1234);
    #1;
    n_checks++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL sub_grant: got %b expected 10", bus.req_ready); end
    @(posedge clk); @(negedge clk);
    bus.req_valid[1] = 1'b0;
    @(posedge clk); @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 2'b10) begin n_fail++; $display("FAIL sub_rsp_valid: got %b expected 10", bus.rsp_valid); end
    n_checks++; if ({bus.rsp_err, bus.rsp_zero, bus.rsp_result} !== {2'b01, 16'h0000}) begin n_fail++; $display("FAIL sub_rsp_data: got err=%b zero=%b res=%h expected 0/1/0000", bus.rsp_err, bus.rsp_zero, bus.rsp_result); end
    @(posedge clk); @(negedge clk);
    model_ptr = 0;
  endtask

  task automatic test_round_robin();
    int n_gr;
    int last;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    rst_n = 1'b0;
    bus.rsp_ready = '1;
    drive_req(0, 3'b010, 16'h0001, 16'h0001);
    drive_req(1, 3'b000, 16'h00FF, 16'h0F0F);
    @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 0;
    n_gr = 0;
    last = 0;
    #1;
    for (int c = 0; c < 40 && n_gr < 4; c++) begin
      if (bus.req_ready !== '0) begin
        exp_ready = N'(1) << (n_gr % 2);
        n_checks++; if (bus.req_ready !== exp_ready) begin n_fail++; $display("FAIL rr_order: grant %0d got %b expected %b", n_gr, bus.req_ready, exp_ready); end
        if (n_gr > 0) begin
          n_checks++; if (c - last != 3) begin n_fail++; $display("FAIL rr_spacing: got %0d cycles expected 3", c - last); end
        end
        n_gr++;
        last = c;
      end
      @(negedge clk); #1;
    end
    n_checks++; if (n_gr != 4) begin n_fail++; $display("FAIL rr_count: got %0d grants expected 4", n_gr); end
    bus.req_valid = '0;
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_drain: got busy=%b expected 0", busy); end
    model_ptr = 0;
  endtask

  task automatic test_stall();
    @(negedge clk);
    bus.rsp_ready = 2'b10;
    drive_req(0, 3'b001, 16'h00F0, 16'h0F00);
    drive_req(1, 3'b010, 16'h0001, 16'h0001);
    #1;
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL stall_grant: got %b expected 01", bus.req_ready); end
    @(posedge clk); @(negedge clk);
    bus.req_valid[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    n_checks++; if ({bus.rsp_valid, bus.rsp_result} !== {2'b01, 16'h0FF0}) begin n_fail++; $display("FAIL stall_first: got valid=%b res=%h expected 01/0ff0", bus.rsp_valid, bus.rsp_result); end
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); @(negedge clk); #1;
      n_checks++; if ({bus.rsp_valid, bus.rsp_result} !== {2'b01, 16'h0FF0}) begin n_fail++; $display("FAIL stall_hold: cycle %0d got valid=%b res=%h expected 01/0ff0", s, bus.rsp_valid, bus.rsp_result); end
      n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL stall_no_grant: cycle %0d got %b expected 00", s, bus.req_ready); end
    end
`ifdef ALU_ARB_STALL_CNT_EN
    n_checks++; if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL stall_cnt: got %0d expected 5", stall_cnt); end
`endif
    bus.rsp_ready = 2'b01;
    bus.req_valid = '0;
    @(posedge clk); @(negedge clk);
    n_checks++; if ({bus.rsp_valid, busy} !== 3'b000) begin n_fail++; $display("FAIL stall_release: got valid=%b busy=%b expected 00/0", bus.rsp_valid, busy); end
    model_ptr = 1;
  endtask

  task automatic test_illegal();
    @(negedge clk);
    bus.rsp_ready = '1;
    drive_req(0, 3'b011, 16'h1234, 16'h5678);
    #1;
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL ill_grant: got %b expected 01", bus.req_ready); end
    @(posedge clk); @(negedge clk);
    bus.req_valid[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    n_checks++; if ({bus.rsp_err, bus.rsp_zero, bus.rsp_result} !== {2'b10, 16'h0000}) begin n_fail++; $display("FAIL ill_rsp: got err=%b zero=%b res=%h expected 1/0/0000", bus.rsp_err, bus.rsp_zero, bus.rsp_result); end
    @(posedge clk); @(negedge clk);
    drive_req(0, 3'b000, 16'hFFFF, 16'h0000);
    @(posedge clk); @(negedge clk);
    bus.req_valid[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    n_checks++; if ({bus.rsp_err, bus.rsp_zero, bus.rsp_result} !== {2'b01, 16'h0000}) begin n_fail++; $display("FAIL ill_next_legal: got err=%b zero=%b res=%h expected 0/1/0000", bus.rsp_err, bus.rsp_zero, bus.rsp_result); end
    @(posedge clk); @(negedge clk);
    model_ptr = 1;
  endtask

  task automatic test_random();
    logic [N-1:0] mask;
    logic [N-1:0] exp_ready;
    logic [2:0]   ops [N];
    logic [W-1:0] as  [N];
    logic [W-1:0] bs  [N];
    logic [W-1:0] r;
    logic [W+1:0] exp;
    int win;
    int stalls;
    @(negedge clk);
    for (int it = 0; it < 30; it++) begin
      mask = N'($urandom_range(0, (1 << N) - 1));
      bus.rsp_ready = '0;
      for (int i = 0; i < N; i++) begin
        ops[i] = 3'($urandom_range(0, 7));
        as[i]  = W'($urandom);
        bs[i]  = ($urandom_range(0, 3) == 0) ? as[i] : W'($urandom);
        if (mask[i]) drive_req(i, ops[i], as[i], bs[i]);
        else bus.req_valid[i] = 1'b0;
      end
      #1;
      if (mask == '0) begin
        n_checks++; if (bus.req_ready !== '0) begin n_fail++; $display("FAIL rnd_idle: got %b expected 0", bus.req_ready); end
        @(posedge clk); @(negedge clk);
        continue;
      end
      win = -1;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (model_ptr + k) % N;
        if (win < 0 && mask[c]) win = c;
      end
      exp_ready = '0;
      exp_ready[win] = 1'b1;
      n_checks++; if (bus.req_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_grant: it %0d got %b expected %b", it, bus.req_ready, exp_ready); end
      if (is_illegal(ops[win])) begin
        exp_q.push_back({1'b1, 1'b0, W'(0)});
      end else begin
        r = alu_ref(ops[win], as[win], bs[win]);
        exp_q.push_back({1'b0, (r == '0), r});
      end
      @(posedge clk); @(negedge clk);
      bus.req_valid[win] = 1'b0;
      #1;
      n_checks++; if ({busy, bus.rsp_valid, bus.req_ready} !== {1'b1, 4'b0000}) begin n_fail++; $display("FAIL rnd_exec: it %0d got busy=%b valid=%b ready=%b expected 1/00/00", it, busy, bus.rsp_valid, bus.req_ready); end
      @(posedge clk); @(negedge clk);
      exp = exp_q.pop_front();
      n_checks++; if (bus.rsp_valid !== exp_ready) begin n_fail++; $display("FAIL rnd_rsp_valid: it %0d got %b expected %b", it, bus.rsp_valid, exp_ready); end
      n_checks++; if ({bus.rsp_err, bus.rsp_zero, bus.rsp_result} !== exp) begin n_fail++; $display("FAIL rnd_rsp_data: it %0d got %h expected %h", it, {bus.rsp_err, bus.rsp_zero, bus.rsp_result}, exp); end
      stalls = $urandom_range(0, 3);
      for (int s = 0; s < stalls; s++) begin
        bus.rsp_ready = N'($urandom) & ~exp_ready;
        @(posedge clk); @(negedge clk);
        n_checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_zero, bus.rsp_result} !== {exp_ready, exp}) begin n_fail++; $display("FAIL rnd_hold: it %0d got %h expected %h", it, {bus.rsp_valid, bus.rsp_err, bus.rsp_zero, bus.rsp_result}, {exp_ready, exp}); end
      end
      bus.rsp_ready = exp_ready | N'($urandom);
      @(posedge clk); @(negedge clk);
      bus.rsp_ready = '0;
      n_checks++; if ({bus.rsp_valid, busy} !== 3'b000) begin n_fail++; $display("FAIL rnd_done: it %0d got valid=%b busy=%b expected 00/0", it, bus.rsp_valid, busy); end
      model_ptr = (win + 1) % N;
    end
    bus.req_valid = '0;
  endtask

  task automatic test_reset_exec();
    @(negedge clk);
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    drive_req(0, 3'b010, 16'h0005, 16'h0006);
    @(posedge clk); @(negedge clk);
    bus.req_valid[0] = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rx_pre_idle: got busy=%b expected 0", busy); end
    drive_req(0, 3'b010, 16'h0007, 16'h0008);
    drive_req(1, 3'b001, 16'h0100, 16'h0001);
    #1;
    n_checks++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL rx_pre_grant: got %b expected 10", bus.req_ready); end
    @(posedge clk); @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rx_in_exec: got busy=%b expected 1", busy); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({bus.req_ready, bus.rsp_valid, busy} !== 5'b0) begin n_fail++; $display("FAIL rx_ctrl_zero: got ready=%b valid=%b busy=%b expected all 0", bus.req_ready, bus.rsp_valid, busy); end
    n_checks++; if ({bus.rsp_result, bus.rsp_zero, bus.rsp_err, alu_op, alu_a, alu_b} !== '0) begin n_fail++; $display("FAIL rx_data_zero: got res=%h op=%h a=%h b=%h expected 0", bus.rsp_result, alu_op, alu_a, alu_b); end
`ifdef ALU_ARB_STALL_CNT_EN
    n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rx_stall_cnt: got %0d expected 0", stall_cnt); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL rx_post_grant: got %b expected 01", bus.req_ready); end
    @(posedge clk); @(negedge clk);
    bus.req_valid = '0;
    n_checks++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rx_no_stale: got %b expected 00", bus.rsp_valid); end
    @(posedge clk); @(negedge clk);
    n_checks++; if ({bus.rsp_valid, bus.rsp_result} !== {2'b01, 16'h000F}) begin n_fail++; $display("FAIL rx_post_rsp: got valid=%b res=%h expected 01/000f", bus.rsp_valid, bus.rsp_result); end
    @(posedge clk); @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rx_post_idle: got busy=%b expected 0", busy); end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '0;
    test_reset();
    test_add_latency();
    test_sub_zero();
    test_round_robin();
    test_stall();
    test_illegal();
    test_random();
    test_reset_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
